// File: rtl/ram_trace_controller.sv
// Trace RAM controller: captures a word stream into a circular buffer on RAM port A and drains it oldest-first from port B.
// Optional macro TRACE_STOP_ON_FULL_EN: stop capturing when full and raise a sticky overflow flag.
module ram_trace_controller #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              dump_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              dump_done,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              ram_clken,
  output logic [ADDR_W-1:0] ram_address_a,
  output logic              ram_wren_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_address_b,
  output logic              ram_wren_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam logic [0:0] ST_CAPTURE = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;
  localparam int FIFO_D = LATENCY + 1;
  localparam int PW     = $clog2(FIFO_D);
  localparam int CW     = $clog2(FIFO_D + 1);
  localparam int OW     = CW + 1;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [0:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   delivered;
  logic [LATENCY-1:0] pipe;
  logic [DATA_W-1:0] fifo_mem [FIFO_D];
  logic [PW-1:0]     fifo_rd;
  logic [PW-1:0]     fifo_wr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     inflight;
  logic [OW-1:0]     occupancy;

  logic              capture;
  logic              full;
  logic              wr_accept;
  logic [ADDR_W:0]   count_after_wr;
  logic [ADDR_W-1:0] wr_ptr_after;
  logic              start_dump;
  logic              issue;
  logic              push;
  logic              pop;
  logic              finish;

  assign capture    = ram_clken && (state == ST_CAPTURE);
  assign full       = (count == FULL_COUNT);
`ifdef TRACE_STOP_ON_FULL_EN
  logic drop;
  assign wr_accept  = capture && in_valid && !full;
  assign drop       = capture && in_valid && full;
`else
  assign wr_accept  = capture && in_valid;
`endif
  assign count_after_wr = (wr_accept && !full) ? count + (ADDR_W+1)'(1) : count;
  assign wr_ptr_after   = wr_accept ? wr_ptr + ADDR_W'(1) : wr_ptr;
  assign start_dump     = capture && dump_req;

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = out_valid ? fifo_mem[fifo_rd] : '0;
  assign out_last  = out_valid && (delivered + (ADDR_W+1)'(1) == count);
  assign pop       = out_valid && out_ready;
  assign finish    = (state == ST_DRAIN) && pop && out_last;
  assign push      = pipe[LATENCY-1];

  // Reads in flight plus words queued, less the word leaving this cycle, must leave room in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(pipe[i]);
    end
    occupancy = OW'(fifo_cnt) + OW'(inflight) - OW'(pop);
    issue     = (state == ST_DRAIN) && (remaining != '0) && (occupancy < OW'(FIFO_D));
  end

  assign busy          = (state == ST_DRAIN);
  assign ram_address_a = wr_ptr;
  assign ram_wren_a    = wr_accept;
  assign ram_data_a    = in_data;
  assign ram_address_b = rd_ptr;
  assign ram_wren_b    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CAPTURE;
      ram_clken <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      delivered <= '0;
      dump_done <= 1'b0;
    end else begin
      ram_clken <= 1'b1;
      dump_done <= 1'b0;
      if (state == ST_CAPTURE) begin
        wr_ptr <= wr_ptr_after;
        count  <= count_after_wr;
        if (start_dump) begin
          if (count_after_wr == '0) begin
            dump_done <= 1'b1;
          end else begin
            state     <= ST_DRAIN;
            // A full buffer has its oldest entry at wr_ptr, which the truncated subtraction yields.
            rd_ptr    <= wr_ptr_after - count_after_wr[ADDR_W-1:0];
            remaining <= count_after_wr;
            delivered <= '0;
          end
        end
      end else begin
        if (issue) begin
          rd_ptr    <= rd_ptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
        end
        if (pop) delivered <= delivered + (ADDR_W+1)'(1);
        if (finish) begin
          state     <= ST_CAPTURE;
          count     <= '0;
          dump_done <= 1'b1;
        end
      end
    end
  end

`ifdef TRACE_STOP_ON_FULL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe     <= '0;
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
    end else begin
      pipe <= (pipe << 1) | LATENCY'(issue);
      if (push) fifo_wr <= (fifo_wr == PW'(FIFO_D - 1)) ? '0 : fifo_wr + PW'(1);
      if (pop)  fifo_rd <= (fifo_rd == PW'(FIFO_D - 1)) ? '0 : fifo_rd + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr] <= ram_q_b;
  end

endmodule

// File: tb/tb_ram_trace_controller.sv
// Scoreboard bench for ram_trace_controller with a behavioural trace-buffer model and a latency-accurate RAM model.
module tb_ram_trace_controller;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int LAT    = 3;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              dump_req = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              dump_done;
  logic              busy;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              ram_clken;
  logic [ADDR_W-1:0] ram_address_a;
  logic              ram_wren_a;
  logic [DATA_W-1:0] ram_data_a;
  logic [ADDR_W-1:0] ram_address_b;
  logic              ram_wren_b;
  logic [DATA_W-1:0] ram_q_b;

  ram_trace_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .dump_req(dump_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .dump_done(dump_done), .busy(busy), .count(count), .overflow(overflow),
    .ram_clken(ram_clken), .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a),
    .ram_data_a(ram_data_a), .ram_address_b(ram_address_b), .ram_wren_b(ram_wren_b),
    .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // RAM model: LATENCY-stage read pipeline that stalls and outputs zero when the clock enable is low.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] qpipe [LAT];
  always @(posedge clk) begin
    if (ram_clken) begin
      if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
      qpipe[0] <= mem[ram_address_b];
      for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
    end
  end
  assign ram_q_b = ram_clken ? qpipe[LAT-1] : '0;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  ovf_exp = 1'b0;
  bit  draining = 1'b0;
  int  dump_len = 0;
  int  dump_cyc = 0;
  bit  first_pending = 1'b0;
  int  first_cyc = 0;
  int  last_hs_cyc = 0;
  int  hs_count = 0;
  bit  stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;
  int  ready_mode = 0;
  bit  [3:0] ready_pat = 4'b1001;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and update the reference model with the effect they should have.
  task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit dump);
    in_valid = v;
    in_data  = d;
    dump_req = dump;
    if (v && !draining) begin
      if (model.size() == DEPTH) begin
`ifdef TRACE_STOP_ON_FULL_EN
        ovf_exp = 1'b1;
`else
        void'(model.pop_front());
        model.push_back(d);
`endif
      end else begin
        model.push_back(d);
      end
    end
    if (dump && !draining) begin
      dump_len = model.size();
      for (int i = 0; i < model.size(); i++) exp_q.push_back({model[i], i == model.size() - 1});
      model.delete();
      draining = (dump_len != 0);
      first_pending = draining;
    end
    @(posedge clk);
    #1;
    if (dump) dump_cyc = cyc;
    in_valid = 1'b0;
    dump_req = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finishDump(input string name);
    bit seen;
    if (dump_len == 0) begin
      @(negedge clk);
      checkOutput({name, "_empty_done"}, dump_done, 1);
      checkOutput({name, "_empty_valid"}, out_valid, 0);
      @(posedge clk);
      #1;
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (dump_done) seen = 1'b1;
    end
    checkOutput({name, "_done_seen"}, seen, 1);
    if (seen) begin
      checkOutput({name, "_all_words"}, exp_q.size(), 0);
      checkOutput({name, "_count_clear"}, count, 0);
      checkOutput({name, "_busy_clear"}, busy, 0);
      checkOutput({name, "_done_timing"}, cyc, last_hs_cyc + 1);
    end
    exp_q.delete();
    draining = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic captureRun(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, base + DATA_W'(i), 1'b0);
  endtask

  // Scoreboard monitor: pops an expected word on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_data", out_data, stall_data);
      end
      if (out_valid && first_pending) begin
        checkOutput("first_latency", cyc, dump_cyc + 1 + LAT);
        first_pending = 1'b0;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_word", out_data, 0);
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e.d);
          checkOutput("out_last", out_last, e.l);
        end
        hs_count++;
        last_hs_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  initial begin
    int pidx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ready_pat[pidx];
          pidx = (pidx + 1) % 4;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_ctrl"}, {out_valid, out_last, dump_done, busy, overflow, ram_clken, ram_wren_a, ram_wren_b}, 0);
    checkOutput({name, "_data"}, out_data, 0);
    checkOutput({name, "_count"}, count, 0);
    checkOutput({name, "_addr"}, {ram_address_a, ram_address_b, ram_data_a}, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    $display("[TB] starting");
    #12;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    idle(3);

    // Empty dump straight after reset
    applyStimulus(1'b0, '0, 1'b1);
    finishDump("empty0");

    // Partial fill with full-rate drain
    ready_mode = 0;
    captureRun(32'h10, 5);
    checkOutput("partial_count", count, model.size());
    applyStimulus(1'b0, '0, 1'b1);
    finishDump("partial");
    checkOutput("partial_throughput", last_hs_cyc - first_cyc, 4);

    // Wrap-around or stop-on-full with 20 words into 16 entries
    captureRun(32'h0, 20);
    checkOutput("wrap_count", count, model.size());
    checkOutput("wrap_overflow", overflow, ovf_exp);
    applyStimulus(1'b0, '0, 1'b1);
    finishDump("wrap");

    // Back-pressure with ready pattern 1,0,0,1
    ready_mode = 1;
    captureRun(32'h200, 8);
    applyStimulus(1'b0, '0, 1'b1);
    finishDump("backpressure");

    // Capture in the dump cycle, then writes during DRAIN that must be ignored
    ready_mode = 0;
    captureRun(32'h1, 2);
    applyStimulus(1'b1, 32'hAA, 1'b1);
    applyStimulus(1'b1, 32'h55, 1'b0);
    applyStimulus(1'b1, 32'h56, 1'b0);
    checkOutput("drain_count_hold", count, 3);
    checkOutput("drain_busy", busy, 1);
    finishDump("simul");
    applyStimulus(1'b0, '0, 1'b1);
    finishDump("empty1");

    // Randomised rounds
    for (int r = 0; r < 8; r++) begin
      ready_mode = $urandom_range(0, 2);
      n = $urandom_range(0, 22);
      for (int i = 0; i < n; i++) begin
        applyStimulus(1'b1, DATA_W'($urandom), 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      checkOutput("rand_count", count, model.size());
      checkOutput("rand_overflow", overflow, ovf_exp);
      applyStimulus($urandom_range(0, 1) == 1, DATA_W'($urandom), 1'b1);
      finishDump("rand");
    end

    // Reset in the middle of a dump
    ready_mode = 1;
    captureRun(32'h300, 8);
    base = hs_count;
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 300 && hs_count < base + 2; i++) @(negedge clk);
    checkOutput("midreset_progress", hs_count >= base + 2, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    exp_q.delete();
    model.delete();
    draining = 1'b0;
    first_pending = 1'b0;
    ovf_exp = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    ready_mode = 0;
    captureRun(32'h400, 3);
    checkOutput("post_reset_count", count, 3);
    applyStimulus(1'b0, '0, 1'b1);
    finishDump("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
